// File: rtl/seg7_pkg.sv
// Shared segment codes, conversion FSM states and sizing helpers for the
// multi-channel BCD display driver.
package seg7_pkg;

  localparam logic [6:0] SEG_D0    = 7'b0000001;
  localparam logic [6:0] SEG_D1    = 7'b1001111;
  localparam logic [6:0] SEG_D2    = 7'b0010010;
  localparam logic [6:0] SEG_D3    = 7'b0000110;
  localparam logic [6:0] SEG_D4    = 7'b1001100;
  localparam logic [6:0] SEG_D5    = 7'b0100100;
  localparam logic [6:0] SEG_D6    = 7'b0100000;
  localparam logic [6:0] SEG_D7    = 7'b0001111;
  localparam logic [6:0] SEG_D8    = 7'b0000000;
  localparam logic [6:0] SEG_D9    = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;
  localparam logic [6:0] SEG_LAMP  = 7'b0000000;

  typedef enum logic [1:0] {
    S_LOAD,
    S_SHIFT,
    S_COMMIT
  } state_t;

  function automatic int max_val(input int digits);
    int v;
    v = 1;
    for (int i = 0; i < digits; i++) v = v * 10;
    return v - 1;
  endfunction

  function automatic int ch_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Nibble to active-low abcdefg code; non-decimal nibbles render dark.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  always_comb begin
    case (i_nib)
      4'd0:    o_seg = SEG_D0;
      4'd1:    o_seg = SEG_D1;
      4'd2:    o_seg = SEG_D2;
      4'd3:    o_seg = SEG_D3;
      4'd4:    o_seg = SEG_D4;
      4'd5:    o_seg = SEG_D5;
      4'd6:    o_seg = SEG_D6;
      4'd7:    o_seg = SEG_D7;
      4'd8:    o_seg = SEG_D8;
      4'd9:    o_seg = SEG_D9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_multi_bcd.sv
// Multi-channel 7-segment driver: one shared shift-add-3 converter walks the
// channels round-robin and commits into a digit store that feeds registered segs.
module seg_multi_bcd
  import seg7_pkg::*;
#(
  parameter int CHANNELS  = 2,
  parameter int DATA_W    = 8,
  parameter int DIGITS    = 2,
  parameter int BLINK_DIV = 25
) (
  input  logic                         clk_divide,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic [CHANNELS*DATA_W-1:0]   data,
  input  logic [CHANNELS-1:0]          lz_blank,
  input  logic [CHANNELS-1:0]          blink,
  output logic [CHANNELS*DIGITS*7-1:0] seg,
  output logic                         frame_done
);

  localparam int MAX_VAL = max_val(DIGITS);
  localparam int CH_W    = ch_width(CHANNELS);
  localparam int BCD_W   = DIGITS * 4;
  localparam int BIT_W   = $clog2(DATA_W + 1);
  localparam int BLK_W   = $clog2(BLINK_DIV);

  localparam logic [DATA_W+31:0] MAX_EXT  = (DATA_W + 32)'(MAX_VAL);
  localparam logic [CH_W-1:0]    CH_LAST  = CH_W'(CHANNELS - 1);
  localparam logic [BIT_W-1:0]   BIT_LAST = BIT_W'(DATA_W - 1);
  localparam logic [BLK_W-1:0]   BLK_LAST = BLK_W'(BLINK_DIV - 1);

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [CH_W-1:0]           r_ch;
  logic [DATA_W-1:0]         r_bin;
  logic [BCD_W-1:0]          r_bcd;
  logic [BIT_W-1:0]          r_bit_cnt;
  logic                      r_ovf_cur;
  logic                      r_frame_done;
  logic [BCD_W-1:0]          r_store [CHANNELS];
  logic [CHANNELS-1:0]       r_ovf;
  logic [BLK_W-1:0]          r_blink_cnt;
  logic                      r_phase;
  logic [CHANNELS*DIGITS*7-1:0] r_seg;
  logic [CHANNELS*DIGITS*7-1:0] w_seg_nxt;
  logic [DATA_W-1:0]         w_sel;
  logic [BCD_W-1:0]          w_adj;
  logic                      w_lz;
  logic [6:0]                w_dec [CHANNELS*DIGITS];

  assign w_sel      = data[int'(r_ch)*DATA_W +: DATA_W];
  assign seg        = r_seg;
  assign frame_done = r_frame_done;

  always_ff @(posedge clk_divide or negedge rst_n) begin
    if (!rst_n) r_state <= S_LOAD;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_LOAD:   w_state_nxt = S_SHIFT;
      S_SHIFT:  if (r_bit_cnt == BIT_LAST) w_state_nxt = S_COMMIT;
      S_COMMIT: w_state_nxt = S_LOAD;
      default:  w_state_nxt = S_LOAD;
    endcase
  end

  always_comb begin
    w_adj = r_bcd;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_bcd[k*4 +: 4] >= 4'd5) w_adj[k*4 +: 4] = r_bcd[k*4 +: 4] + 4'd3;
    end
  end

  // Carries out of the top nibble are dropped; overflowed channels show dashes anyway.
  always_ff @(posedge clk_divide or negedge rst_n) begin
    if (!rst_n) begin
      r_ch         <= '0;
      r_bin        <= '0;
      r_bcd        <= '0;
      r_bit_cnt    <= '0;
      r_ovf_cur    <= 1'b0;
      r_frame_done <= 1'b0;
      r_ovf        <= '0;
      for (int c = 0; c < CHANNELS; c++) r_store[c] <= '0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_LOAD: begin
          r_bin     <= w_sel;
          r_bcd     <= '0;
          r_ovf_cur <= ({32'd0, w_sel} > MAX_EXT);
          r_bit_cnt <= '0;
        end
        S_SHIFT: begin
          r_bcd     <= {w_adj[BCD_W-2:0], r_bin[DATA_W-1]};
          r_bin     <= r_bin << 1;
          r_bit_cnt <= r_bit_cnt + BIT_W'(1);
        end
        S_COMMIT: begin
          r_store[r_ch] <= r_bcd;
          r_ovf[r_ch]   <= r_ovf_cur;
          r_frame_done  <= (r_ch == CH_LAST);
          r_ch          <= (r_ch == CH_LAST) ? '0 : r_ch + CH_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_divide or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b1;
    end else if (r_blink_cnt == BLK_LAST) begin
      r_blink_cnt <= '0;
      r_phase     <= ~r_phase;
    end else begin
      r_blink_cnt <= r_blink_cnt + BLK_W'(1);
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    for (genvar d = 0; d < DIGITS; d++) begin : g_dig
      seg7_decode u_dec (
        .i_nib (r_store[c][d*4 +: 4]),
        .o_seg (w_dec[c*DIGITS+d])
      );
    end
  end

  // A digit is a leading zero when it and every more-significant digit are zero.
  always_comb begin
    w_seg_nxt = '1;
    w_lz      = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      for (int d = 0; d < DIGITS; d++) begin
        w_lz = (d > 0);
        for (int k = 0; k < DIGITS; k++) begin
          if (k >= d && r_store[c][k*4 +: 4] != 4'd0) w_lz = 1'b0;
        end
        if (!enable)                   w_seg_nxt[(c*DIGITS+d)*7 +: 7] = SEG_LAMP;
        else if (blink[c] && !r_phase) w_seg_nxt[(c*DIGITS+d)*7 +: 7] = SEG_BLANK;
        else if (r_ovf[c])             w_seg_nxt[(c*DIGITS+d)*7 +: 7] = SEG_DASH;
        else if (lz_blank[c] && w_lz)  w_seg_nxt[(c*DIGITS+d)*7 +: 7] = SEG_BLANK;
        else                           w_seg_nxt[(c*DIGITS+d)*7 +: 7] = w_dec[c*DIGITS+d];
      end
    end
  end

  always_ff @(posedge clk_divide or negedge rst_n) begin
    if (!rst_n) r_seg <= '1;
    else        r_seg <= w_seg_nxt;
  end

endmodule

// File: tb/tb_seg_multi_bcd.sv
// Directed bench for seg_multi_bcd: reset, conversion, overflow, lamp test,
// blink cadence and data sampling window.
module tb_seg_multi_bcd;

  localparam int CH = 2;
  localparam int DW = 8;
  localparam int DG = 2;
  localparam int BD = 4;

  localparam logic [6:0] C0 = 7'b0000001;
  localparam logic [6:0] C2 = 7'b0010010;
  localparam logic [6:0] C3 = 7'b0000110;
  localparam logic [6:0] C4 = 7'b1001100;
  localparam logic [6:0] C6 = 7'b0100000;
  localparam logic [6:0] C7 = 7'b0001111;
  localparam logic [6:0] C8 = 7'b0000000;
  localparam logic [6:0] C9 = 7'b0000100;
  localparam logic [6:0] DK = 7'b1111111;
  localparam logic [6:0] DS = 7'b1111110;

  logic               clk_divide = 1'b0;
  logic               rst_n      = 1'b0;
  logic               enable     = 1'b1;
  logic [CH*DW-1:0]   data       = '0;
  logic [CH-1:0]      lz_blank   = '0;
  logic [CH-1:0]      blink      = '0;
  logic [CH*DG*7-1:0] seg;
  logic               frame_done;

  int checks = 0;
  int errors = 0;
  int ecnt;

  seg_multi_bcd #(
    .CHANNELS  (CH),
    .DATA_W    (DW),
    .DIGITS    (DG),
    .BLINK_DIV (BD)
  ) dut (
    .clk_divide (clk_divide),
    .rst_n      (rst_n),
    .enable     (enable),
    .data       (data),
    .lz_blank   (lz_blank),
    .blink      (blink),
    .seg        (seg),
    .frame_done (frame_done)
  );

  always #5 clk_divide = ~clk_divide;

  always @(posedge clk_divide or negedge rst_n) begin
    if (!rst_n) ecnt <= 0;
    else        ecnt <= ecnt + 1;
  end

  function automatic logic [13:0] chan(input int c);
    return seg[c*14 +: 14];
  endfunction

  task automatic tick;
    @(posedge clk_divide);
    #1;
  endtask

  task automatic wait_frame;
    int n;
    n = 0;
    do begin
      tick;
      n++;
    end while (frame_done !== 1'b1 && n < 60);
    if (frame_done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL wait_frame: frame_done=%b after %0d cycles, required 1", frame_done, n);
    end
  endtask

  task automatic test_reset;
    int n;
    rst_n = 1'b0;
    data  = {8'd7, 8'd42};
    repeat (2) tick;
    checks++;
    if (seg !== '1 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL por_state: seg=%b fd=%b, required all ones and 0", seg, frame_done);
    end
    rst_n = 1'b1;
    wait_frame;
    wait_frame;
    repeat (3) tick;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (seg !== '1) begin
      errors++;
      $display("FAIL async_dark: seg=%b, required all ones", seg);
    end
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL async_fd: frame_done=%b, required 0", frame_done);
    end
    repeat (2) tick;
    checks++;
    if (seg !== '1) begin
      errors++;
      $display("FAIL held_dark: seg=%b, required all ones", seg);
    end
    #2 rst_n = 1'b1;
    tick;
    n = 1;
    checks++;
    if (seg !== {C0, C0, C0, C0}) begin
      errors++;
      $display("FAIL store_cleared: seg=%b, required %b", seg, {C0, C0, C0, C0});
    end
    while (frame_done !== 1'b1 && n < 60) begin
      tick;
      n++;
    end
    checks++;
    if (n !== 20) begin
      errors++;
      $display("FAIL first_frame: cycles=%0d, required 20", n);
    end
    n = 0;
    do begin
      tick;
      n++;
    end while (frame_done !== 1'b1 && n < 60);
    checks++;
    if (n !== 20) begin
      errors++;
      $display("FAIL frame_period: cycles=%0d, required 20", n);
    end
  endtask

  task automatic test_conversion;
    data     = {8'd7, 8'd42};
    lz_blank = 2'b10;
    wait_frame;
    wait_frame;
    tick;
    checks++;
    if (chan(0) !== {C4, C2}) begin
      errors++;
      $display("FAIL conv_42: got %b, required %b", chan(0), {C4, C2});
    end
    checks++;
    if (chan(1) !== {DK, C7}) begin
      errors++;
      $display("FAIL conv_7_lz: got %b, required %b", chan(1), {DK, C7});
    end
    lz_blank = 2'b00;
    tick;
    checks++;
    if (chan(1) !== {C0, C7}) begin
      errors++;
      $display("FAIL conv_7_nolz: got %b, required %b", chan(1), {C0, C7});
    end
    data     = {8'd7, 8'd0};
    lz_blank = 2'b01;
    wait_frame;
    wait_frame;
    tick;
    checks++;
    if (chan(0) !== {DK, C0}) begin
      errors++;
      $display("FAIL conv_0_lz: got %b, required %b", chan(0), {DK, C0});
    end
    lz_blank = 2'b00;
  endtask

  task automatic test_overflow;
    data = {8'd7, 8'd150};
    wait_frame;
    wait_frame;
    tick;
    checks++;
    if (chan(0) !== {DS, DS}) begin
      errors++;
      $display("FAIL ovf_150: got %b, required %b", chan(0), {DS, DS});
    end
    checks++;
    if (chan(1) !== {C0, C7}) begin
      errors++;
      $display("FAIL ovf_other_ch: got %b, required %b", chan(1), {C0, C7});
    end
    data = {8'd7, 8'd100};
    wait_frame;
    wait_frame;
    tick;
    checks++;
    if (chan(0) !== {DS, DS}) begin
      errors++;
      $display("FAIL ovf_100: got %b, required %b", chan(0), {DS, DS});
    end
    data = {8'd7, 8'd99};
    wait_frame;
    wait_frame;
    tick;
    checks++;
    if (chan(0) !== {C9, C9}) begin
      errors++;
      $display("FAIL max_99: got %b, required %b", chan(0), {C9, C9});
    end
  endtask

  task automatic test_lamp;
    int n;
    data = {8'd7, 8'd42};
    wait_frame;
    wait_frame;
    n = 0;
    enable = 1'b0;
    tick;
    n++;
    checks++;
    if (seg !== '0) begin
      errors++;
      $display("FAIL lamp_on: seg=%b, required all zeros", seg);
    end
    enable = 1'b1;
    tick;
    n++;
    checks++;
    if (seg !== {C0, C7, C4, C2}) begin
      errors++;
      $display("FAIL lamp_off: seg=%b, required %b", seg, {C0, C7, C4, C2});
    end
    while (frame_done !== 1'b1 && n < 60) begin
      tick;
      n++;
    end
    checks++;
    if (n !== 20) begin
      errors++;
      $display("FAIL lamp_cadence: cycles=%0d, required 20", n);
    end
  endtask

  task automatic test_blink;
    logic [13:0] exp0;
    int k;
    blink = 2'b01;
    for (int i = 0; i < 8; i++) begin
      tick;
      k = ecnt;
      // phase in force before edge k; visible in the first BD edges after release
      exp0 = ((((k - 1) / BD) % 2) == 0) ? {C4, C2} : {DK, DK};
      checks++;
      if (chan(0) !== exp0) begin
        errors++;
        $display("FAIL blink_ch0 edge %0d: got %b, required %b", k, chan(0), exp0);
      end
      checks++;
      if (chan(1) !== {C0, C7}) begin
        errors++;
        $display("FAIL blink_ch1 edge %0d: got %b, required %b", k, chan(1), {C0, C7});
      end
    end
    blink = 2'b00;
  endtask

  task automatic test_sampling;
    wait_frame;
    tick;
    data[15:8] = 8'd63;
    repeat (19) tick;
    checks++;
    if (chan(1) !== {C0, C7}) begin
      errors++;
      $display("FAIL samp_before: got %b, required %b", chan(1), {C0, C7});
    end
    tick;
    checks++;
    if (chan(1) !== {C6, C3}) begin
      errors++;
      $display("FAIL samp_latency: got %b, required %b", chan(1), {C6, C3});
    end
    repeat (11) tick;
    data[15:8] = 8'd88;
    repeat (9) tick;
    checks++;
    if (chan(1) !== {C6, C3}) begin
      errors++;
      $display("FAIL samp_ignored: got %b, required %b", chan(1), {C6, C3});
    end
    repeat (19) tick;
    checks++;
    if (chan(1) !== {C6, C3}) begin
      errors++;
      $display("FAIL samp_hold: got %b, required %b", chan(1), {C6, C3});
    end
    tick;
    checks++;
    if (chan(1) !== {C8, C8}) begin
      errors++;
      $display("FAIL samp_next: got %b, required %b", chan(1), {C8, C8});
    end
  endtask

  initial begin
    test_reset;
    test_conversion;
    test_overflow;
    test_lamp;
    test_blink;
    test_sampling;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
